alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares a single 32-bit ALU between two requesters (the EX-stage pipeline slot and a secondary issuer such as a multi-cycle address/branch helper) using round-robin arbitration and valid/ready handshakes. Each accepted operation is evaluated in one pass and held in a one-entry registered result slot, tagged with the winning requester's ID, until the consumer takes it. The block replaces duplicated ALUs where area matters and one operation per cycle is sufficient throughput.

## Interface
- PRIORITY_INIT, 0, requester that wins the first contention after reset (0 or 1)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 presents an operation
- req0_ready  output  1  requester 0 operation accepted this cycle (when valid)
- req0_ctrl  input  4  requester 0 ALU control code
- req0_in1, req0_in2  input  32  requester 0 signed operands
- req0_shamt  input  5  requester 0 immediate shift amount
- req1_valid, req1_ready, req1_ctrl, req1_in1, req1_in2, req1_shamt  same as requester 0, for requester 1
- rsp_valid  output  1  result slot occupied
- rsp_ready  input  1  consumer takes the result this cycle
- rsp_id  output  1  requester that issued the held result
- rsp_data  output  32  held result

## Operation
- Control codes: 1 ADD, 2 AND, 3 OR, 4 SUB (in1 - in2, two's complement), 5 SLL by shamt, 6 SRL by shamt, 7 SRA by shamt, 8 LESS (signed in1 < in2 gives 1, else 0), 9 NOR, A SLLV, B SRLV, C SRAV. Variable shifts use in2[4:0]. Codes 0, D, E, F yield 0. Arithmetic wraps modulo 2^32; no overflow flag.
- Slot free when rsp_valid = 0 or (rsp_valid & rsp_ready).
- Arbitration, evaluated every cycle:
  - only one requester valid: that requester is granted;
  - both valid: the requester named by the priority pointer is granted;
  - neither valid: no grant.
- reqX_ready = grant_X & slot free. At most one ready is high per cycle. ready may depend combinationally on both valids, rsp_valid and rsp_ready. Requesters must not make valid depend on ready.
- Transfer occurs when reqX_valid & reqX_ready. The slot loads the ALU result of X's operands, rsp_id = X, and rsp_valid = 1.
- The priority pointer updates only on a transfer: after X is served, the pointer becomes the other requester. No transfer leaves the pointer unchanged.
- Result consumed (rsp_valid & rsp_ready) with no new transfer: rsp_valid = 0. rsp_data and rsp_id keep their last values.
- Requester rules: once valid is asserted it stays high with stable operands until accepted. The block does not buffer rejected requests.

## Timing
- Reset values: rsp_valid = 0, rsp_id = 0, rsp_data = 0, priority pointer = PRIORITY_INIT. req0_ready and req1_ready are 0 during reset, regardless of inputs.
- Latency: a transfer at edge N gives rsp_valid = 1 with the result from edge N until the consume edge.
- Throughput: one operation per cycle while rsp_ready is held at 1, including back-to-back transfers over a consume edge (consume and load happen on the same edge).
- Backpressure: with rsp_valid = 1 and rsp_ready = 0, both readies are 0, and rsp_data/rsp_id are held bit-stable.
- Reset asserted mid-operation: the held result is discarded, rsp_valid = 0 on the next edge, and the pointer returns to PRIORITY_INIT. No transfer happens on a reset edge.
- Contention is alternating-fair: with both requesters continuously valid and no backpressure, grants strictly alternate.

## Test plan
- Reset then a single request: req0 ADD 7 + (-3) -> req0_ready = 1 that cycle; next cycle rsp_valid = 1, rsp_id = 0, rsp_data = 4.
- Contention with PRIORITY_INIT = 0: both valid, rsp_ready = 1 for 4 cycles, req0 SUB 5 - 9, req1 SRA 0x80000000 shamt 4 -> grants 0,1,0,1; results 0xFFFFFFFC (id 0) and 0xF8000000 (id 1), alternating.
- Backpressure: slot holds LESS -1 < 1 = 1 while rsp_ready = 0 for 3 cycles with req1 valid -> req1_ready = 0, rsp_data stays 1. On the rsp_ready = 1 cycle, req1 transfers, and the next cycle shows the req1 result.
- Ops and width: SLLV 1 by in2 = 0x23 -> 8 (uses in2[4:0] = 3); NOR 0 | 0 -> 0xFFFFFFFF; code 0xE -> 0; ADD 0x7FFFFFFF + 1 -> 0x80000000.
- Mid-operation reset: occupied slot with the pointer at 1, assert reset for one cycle -> rsp_valid = 0, rsp_data = 0. Then both valid -> requester 0 (PRIORITY_INIT) granted first.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared 32-bit ALU, with a
// one-entry registered result slot tagged by the winning requester.
module alu_arbiter #(
    parameter bit PRIORITY_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_ctrl,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic [4:0]  req0_shamt,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_ctrl,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    input  logic [4:0]  req1_shamt,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [CTRL_W-1:0] OP_ADD  = 4'h1;
    localparam logic [CTRL_W-1:0] OP_AND  = 4'h2;
    localparam logic [CTRL_W-1:0] OP_OR   = 4'h3;
    localparam logic [CTRL_W-1:0] OP_SUB  = 4'h4;
    localparam logic [CTRL_W-1:0] OP_SLL  = 4'h5;
    localparam logic [CTRL_W-1:0] OP_SRL  = 4'h6;
    localparam logic [CTRL_W-1:0] OP_SRA  = 4'h7;
    localparam logic [CTRL_W-1:0] OP_LESS = 4'h8;
    localparam logic [CTRL_W-1:0] OP_NOR  = 4'h9;
    localparam logic [CTRL_W-1:0] OP_SLLV = 4'hA;
    localparam logic [CTRL_W-1:0] OP_SRLV = 4'hB;
    localparam logic [CTRL_W-1:0] OP_SRAV = 4'hC;

    // Single-pass ALU; unused codes evaluate to zero.
    function automatic logic [DATA_W-1:0] alu_eval(
        input logic [CTRL_W-1:0]  ctrl,
        input logic [DATA_W-1:0]  in1,
        input logic [DATA_W-1:0]  in2,
        input logic [SHAMT_W-1:0] shamt
    );
        logic [DATA_W-1:0]  res;
        logic [SHAMT_W-1:0] vsh;
        res = '0;
        vsh = in2[SHAMT_W-1:0];
        case (ctrl)
            OP_ADD:  res = in1 + in2;
            OP_AND:  res = in1 & in2;
            OP_OR:   res = in1 | in2;
            OP_SUB:  res = in1 - in2;
            OP_SLL:  res = in1 << shamt;
            OP_SRL:  res = in1 >> shamt;
            OP_SRA:  res = DATA_W'($signed(in1) >>> shamt);
            OP_LESS: res = DATA_W'($signed(in1) < $signed(in2));
            OP_NOR:  res = ~(in1 | in2);
            OP_SLLV: res = in1 << vsh;
            OP_SRLV: res = in1 >> vsh;
            OP_SRAV: res = DATA_W'($signed(in1) >>> vsh);
            default: res = '0;
        endcase
        return res;
    endfunction

    logic                prio_ptr;
    logic                slot_free;
    logic                grant0;
    logic                grant1;
    logic                xfer0;
    logic                xfer1;
    logic                sel1;
    logic [CTRL_W-1:0]   op_ctrl;
    logic [DATA_W-1:0]   op_in1;
    logic [DATA_W-1:0]   op_in2;
    logic [SHAMT_W-1:0]  op_shamt;
    logic [DATA_W-1:0]   alu_result;

    // Grant selection and ready generation; readies are forced low in reset.
    always_comb begin
        slot_free  = ~rsp_valid | rsp_ready;
        grant0     = req0_valid & (~req1_valid | ~prio_ptr);
        grant1     = req1_valid & (~req0_valid |  prio_ptr);
        req0_ready = ~reset & grant0 & slot_free;
        req1_ready = ~reset & grant1 & slot_free;
        xfer0      = req0_valid & req0_ready;
        xfer1      = req1_valid & req1_ready;
    end

    // Operand mux follows the transferring requester.
    always_comb begin
        sel1       = xfer1;
        op_ctrl    = sel1 ? req1_ctrl  : req0_ctrl;
        op_in1     = sel1 ? req1_in1   : req0_in1;
        op_in2     = sel1 ? req1_in2   : req0_in2;
        op_shamt   = sel1 ? req1_shamt : req0_shamt;
        alu_result = alu_eval(op_ctrl, op_in1, op_in2, op_shamt);
    end

    // Result slot and round-robin pointer; a consume and a load may share an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            prio_ptr  <= PRIORITY_INIT;
        end else if (xfer0 | xfer1) begin
            rsp_valid <= 1'b1;
            rsp_id    <= xfer1;
            rsp_data  <= alu_result;
            prio_ptr  <= ~xfer1;
        end else if (rsp_valid & rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: driver predicts grants and results from a
// behavioural model, a negedge monitor checks every presented result.
module tb_alu_arbiter;

    typedef struct packed {
        logic        v;
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  s;
    } op_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
    logic [31:0] req0_in1 = '0, req0_in2 = '0, req1_in1 = '0, req1_in2 = '0;
    logic [4:0]  req0_shamt = '0, req1_shamt = '0;
    logic        rsp_valid, rsp_id, rsp_ready = 1'b0;
    logic [31:0] rsp_data;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    logic        m_valid = 1'b0;
    logic        m_ptr = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.PRIORITY_INIT(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_shamt(req1_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference ALU written from the operation table.
    function automatic logic [31:0] ref_alu(input op_t o);
        int sa, sb;
        logic [31:0] fill;
        logic [4:0]  n;
        sa = int'(o.a);
        sb = int'(o.b);
        n  = (o.c >= 4'hA) ? o.b[4:0] : o.s;
        fill = o.a[31] ? ~(32'hFFFF_FFFF >> n) : 32'h0;
        case (o.c)
            4'h1: return o.a + o.b;
            4'h2: return o.a & o.b;
            4'h3: return o.a | o.b;
            4'h4: return o.a + ~o.b + 32'd1;
            4'h5, 4'hA: return o.a << n;
            4'h6, 4'hB: return o.a >> n;
            4'h7, 4'hC: return fill | (o.a >> n);
            4'h8: return (sa < sb) ? 32'd1 : 32'd0;
            4'h9: return ~(o.a | o.b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic op_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] s);
        op_t o;
        o.v = 1'b1; o.c = c; o.a = a; o.b = b; o.s = s;
        return o;
    endfunction

    localparam op_t IDLE = '0;

    // One clock of stimulus: drive, compare readies to the model, record predictions.
    task automatic step(input op_t r0, input op_t r1, input logic rr,
                        output logic acc0, output logic acc1);
        logic free, g0, g1;
        @(posedge clk); #1;
        req0_valid = r0.v; req0_ctrl = r0.c; req0_in1 = r0.a; req0_in2 = r0.b; req0_shamt = r0.s;
        req1_valid = r1.v; req1_ctrl = r1.c; req1_in1 = r1.a; req1_in2 = r1.b; req1_shamt = r1.s;
        rsp_ready = rr;
        #2;
        free = !m_valid || rr;
        g0 = r0.v && (!r1.v || m_ptr == 1'b0);
        g1 = r1.v && (!r0.v || m_ptr == 1'b1);
        acc0 = g0 && free;
        acc1 = g1 && free;
        chk("req0_ready", 33'(req0_ready), 33'(acc0));
        chk("req1_ready", 33'(req1_ready), 33'(acc1));
        chk("rsp_valid", 33'(rsp_valid), 33'(m_valid));
        if (acc0) begin exp_q.push_back({1'b0, ref_alu(r0)}); m_ptr = 1'b1; end
        if (acc1) begin exp_q.push_back({1'b1, ref_alu(r1)}); m_ptr = 1'b0; end
        if (acc0 || acc1) m_valid = 1'b1;
        else if (m_valid && rr) m_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        #2;
        chk("reset_req0_ready", 33'(req0_ready), 33'd0);
        chk("reset_req1_ready", 33'(req1_ready), 33'd0);
        exp_q.delete();
        m_valid = 1'b0;
        m_ptr   = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        #2;
        chk("reset_rsp_valid", 33'(rsp_valid), 33'd0);
        chk("reset_rsp_data", 33'(rsp_data), 33'd0);
        chk("reset_rsp_id", 33'(rsp_id), 33'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: whenever a result is presented it must match the oldest prediction.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 33'(rsp_valid), 33'd0);
            end else begin
                chk("rsp_id_data", {rsp_id, rsp_data}, exp_q[0]);
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic a0, a1;
        op_t  p0, p1;
        logic rr;

        do_reset();

        // Contention from reset: grants alternate starting with requester 0.
        for (int i = 0; i < 4; i++) begin
            step(mk(4'h4, 32'd5, 32'd9, 5'd0), mk(4'h7, 32'h8000_0000, 32'd0, 5'd4), 1'b1, a0, a1);
            chk("contention_grant0", 33'(a0), 33'((i % 2) == 0));
        end
        step(IDLE, IDLE, 1'b1, a0, a1);
        step(IDLE, IDLE, 1'b1, a0, a1);

        do_reset();
        step(mk(4'h1, 32'd7, 32'hFFFF_FFFD, 5'd0), IDLE, 1'b0, a0, a1);
        step(IDLE, IDLE, 1'b0, a0, a1);
        chk("add_7_m3", {rsp_id, rsp_data}, {1'b0, 32'd4});
        step(IDLE, IDLE, 1'b1, a0, a1);

        // Backpressure: LESS result held while requester 1 waits.
        step(mk(4'h8, 32'hFFFF_FFFF, 32'd1, 5'd0), IDLE, 1'b1, a0, a1);
        for (int i = 0; i < 3; i++) begin
            step(IDLE, mk(4'h3, 32'h00F0, 32'h0F00, 5'd0), 1'b0, a0, a1);
            chk("bp_hold_data", 33'(rsp_data), 33'd1);
        end
        step(IDLE, mk(4'h3, 32'h00F0, 32'h0F00, 5'd0), 1'b1, a0, a1);
        step(IDLE, IDLE, 1'b0, a0, a1);
        chk("bp_or_result", {rsp_id, rsp_data}, {1'b1, 32'h0FF0});
        step(IDLE, IDLE, 1'b1, a0, a1);

        // Individual op corners through the scoreboard.
        step(mk(4'hA, 32'd1, 32'h23, 5'd0), IDLE, 1'b1, a0, a1);
        step(mk(4'h9, 32'd0, 32'd0, 5'd0), IDLE, 1'b1, a0, a1);
        chk("sllv_result", 33'(rsp_data), 33'd8);
        step(mk(4'hE, 32'h1234, 32'h5678, 5'd3), IDLE, 1'b1, a0, a1);
        chk("nor_result", 33'(rsp_data), 33'hFFFF_FFFF);
        step(mk(4'h1, 32'h7FFF_FFFF, 32'd1, 5'd0), IDLE, 1'b1, a0, a1);
        chk("code_e_result", 33'(rsp_data), 33'd0);
        step(IDLE, IDLE, 1'b1, a0, a1);
        chk("add_wrap_result", 33'(rsp_data), 33'h8000_0000);

        // Mid-operation reset with pointer at 1, then requester 0 must win.
        step(mk(4'h2, 32'hFF, 32'h0F, 5'd0), IDLE, 1'b0, a0, a1);
        step(IDLE, IDLE, 1'b0, a0, a1);
        do_reset();
        step(mk(4'h1, 32'd1, 32'd2, 5'd0), mk(4'h1, 32'd3, 32'd4, 5'd0), 1'b1, a0, a1);
        chk("post_reset_first_grant", 33'(a0), 33'd1);

        // Randomized traffic honoring the hold-until-accepted rule.
        p0 = IDLE; p1 = IDLE;
        for (int i = 0; i < 800; i++) begin
            if (!p0.v && $urandom_range(0, 2) != 0)
                p0 = mk(4'($urandom_range(0, 15)), rand_operand(), rand_operand(), 5'($urandom));
            if (!p1.v && $urandom_range(0, 2) != 0)
                p1 = mk(4'($urandom_range(0, 15)), rand_operand(), rand_operand(), 5'($urandom));
            rr = ($urandom_range(0, 3) != 0);
            step(p0, p1, rr, a0, a1);
            if (a0) p0 = IDLE;
            if (a1) p1 = IDLE;
            if (i == 400) begin
                do_reset();
                p0 = IDLE; p1 = IDLE;
            end
        end

        for (int i = 0; i < 3; i++) step(IDLE, IDLE, 1'b1, a0, a1);
        @(negedge clk);
        chk("scoreboard_drained", 33'(exp_q.size()), 33'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
